// File: rtl/divider_nonres_seq_pkg.sv
// Shared multdiv definitions: divider FSM encoding, counter sizing and
// two's-complement helpers (also used by the multiplier).
package divider_nonres_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Helpers work on a 64-bit carrier; callers cast back down to their width.
  localparam int MAX_W = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                               input logic             sign);
    return sign ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/divider_nonres_step.sv
// One combinational non-restoring division step on a {R, Q} register,
// where R carries one extra bit so its sign survives the add/subtract.
module divider_nonres_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] rq_in,
  input  logic [WIDTH-1:0] d,
  output logic [2*WIDTH:0] rq_out
);

  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_new;
  logic [WIDTH-1:0] q;

  // The shifted value may need WIDTH+2 bits, but the result after +/-D is
  // always in [-D, D), so modulo 2^(WIDTH+1) arithmetic stays exact.
  always_comb begin
    r      = rq_in[2*WIDTH:WIDTH];
    q      = rq_in[WIDTH-1:0];
    r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    r_new  = r[WIDTH] ? (r_sh + {1'b0, d}) : (r_sh - {1'b0, d});
    rq_out = {r_new, q[WIDTH-2:0], ~r_new[WIDTH]};
  end

endmodule

// File: rtl/divider_nonres_seq.sv
// Multi-cycle non-restoring integer divider with start/ready handshake,
// optional signed mode, divide-by-zero flag and abort-on-restart.
module divider_nonres_seq
  import divider_nonres_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             exception,
  output div_state_t       fsm_state
);

  // Handshake: start is a single-cycle request accepted in any state (a start
  // while busy aborts the running operation); ready is a one-cycle pulse and
  // quotient/remainder/exception stay valid until the next accepted start.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [2*WIDTH:0] rq;
  logic [2*WIDTH:0] rq_step;
  logic [WIDTH-1:0] d;
  logic             q_neg;
  logic             r_neg;
  logic [CW-1:0]    cnt;

  logic             signed_op;
  logic             div_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  divider_nonres_step #(.WIDTH(WIDTH)) u_step (
    .rq_in  (rq),
    .d      (d),
    .rq_out (rq_step)
  );

  always_comb begin
    signed_op = SIGNED_EN && is_signed;
    div_zero  = (divisor == '0);
    dvd_mag   = dividend;
    dvs_mag   = divisor;
    if (signed_op) begin
      dvd_mag = WIDTH'(abs_val(MAX_W'(dividend), dividend[WIDTH-1]));
      dvs_mag = WIDTH'(abs_val(MAX_W'(divisor), divisor[WIDTH-1]));
    end
  end

  // Final correction: a negative partial remainder is one divisor short.
  always_comb begin
    r_mag = rq[2*WIDTH] ? (rq[2*WIDTH-1:WIDTH] + d) : rq[2*WIDTH-1:WIDTH];
    q_res = q_neg ? WIDTH'(twos_neg(MAX_W'(rq[WIDTH-1:0]))) : rq[WIDTH-1:0];
    r_res = r_neg ? WIDTH'(twos_neg(MAX_W'(r_mag))) : r_mag;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = div_zero ? DONE : ITER;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ITER:    if (cnt == LAST_STEP) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rq        <= '0;
      d         <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      exception <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        rq        <= {{(WIDTH+1){1'b0}}, dvd_mag};
        d         <= dvs_mag;
        q_neg     <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg     <= signed_op && dividend[WIDTH-1];
        cnt       <= '0;
        exception <= div_zero;
        busy      <= !div_zero;
        if (div_zero) begin
          quotient  <= '0;
          remainder <= '0;
          ready     <= 1'b1;
        end
      end else begin
        case (state)
          ITER: begin
            rq  <= rq_step;
            cnt <= cnt + 1'b1;
          end
          FIX: begin
            quotient  <= q_res;
            remainder <= r_res;
            ready     <= 1'b1;
            busy      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_divider_nonres_seq.sv
// Scoreboarded bench for divider_nonres_seq: a 32-bit signed-capable instance
// and two 8-bit instances (signed-capable and unsigned-only) sharing stimulus.
module tb_divider_nonres_seq;
  import divider_nonres_seq_pkg::*;

  localparam int W = 32;
  localparam int P = 10;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic clear;

  // 32-bit instance
  logic          start, is_signed;
  logic [W-1:0]  dividend, divisor, quotient, remainder;
  logic          ready, busy, exception;
  div_state_t    st32;

  // 8-bit instances, shared inputs
  logic          start8, is_signed8;
  logic [7:0]    dvd8, dvs8, qa, ra, qb, rb;
  logic          ready_a, busy_a, exc_a, ready_b, busy_b, exc_b;
  div_state_t    st_a, st_b;

  divider_nonres_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) u32 (
    .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .ready(ready), .busy(busy), .exception(exception),
    .fsm_state(st32));

  divider_nonres_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
    .clock(clock), .clear(clear), .start(start8), .is_signed(is_signed8),
    .dividend(dvd8), .divisor(dvs8), .quotient(qa), .remainder(ra),
    .ready(ready_a), .busy(busy_a), .exception(exc_a), .fsm_state(st_a));

  divider_nonres_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
    .clock(clock), .clear(clear), .start(start8), .is_signed(is_signed8),
    .dividend(dvd8), .divisor(dvs8), .quotient(qb), .remainder(rb),
    .ready(ready_b), .busy(busy_b), .exception(exc_b), .fsm_state(st_b));

  // ---------------- scoreboard ----------------
  // entry = {latency[7:0], exception, remainder[31:0], quotient[31:0]}
  logic [72:0] exp_q32[$], exp_qa[$], exp_qb[$];
  time         t_q32[$], t_qa[$], t_qb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: wide signed arithmetic truncated to w bits.
  function automatic logic [72:0] model(input int w, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - w);
    if (b == 32'd0) return {8'd0, 1'b1, 32'd0, 32'd0};
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    return {8'(w + 1), 1'b0, 32'(r) & mask, 32'(q) & mask};
  endfunction

  task automatic score(input string tag, input logic [31:0] q, input logic [31:0] r,
                       input logic exc, input logic bsy, input logic [72:0] e, input time t0);
    check({tag, "_quotient"}, q, e[31:0]);
    check({tag, "_remainder"}, r, e[63:32]);
    check({tag, "_exception"}, exc, e[64]);
    check({tag, "_latency"}, ($time - t0 - 5) / P, e[72:65]);
    check({tag, "_busy_in_ready"}, bsy, 0);
  endtask

  always @(negedge clock) if (ready === 1'b1) begin
    check("u32_ready_expected", exp_q32.size() != 0, 1);
    if (exp_q32.size() != 0)
      score("u32", quotient, remainder, exception, busy, exp_q32.pop_front(), t_q32.pop_front());
  end

  always @(negedge clock) if (ready_a === 1'b1) begin
    check("u8s_ready_expected", exp_qa.size() != 0, 1);
    if (exp_qa.size() != 0)
      score("u8s", {24'd0, qa}, {24'd0, ra}, exc_a, busy_a, exp_qa.pop_front(), t_qa.pop_front());
  end

  always @(negedge clock) if (ready_b === 1'b1) begin
    check("u8u_ready_expected", exp_qb.size() != 0, 1);
    if (exp_qb.size() != 0)
      score("u8u", {24'd0, qb}, {24'd0, rb}, exc_b, busy_b, exp_qb.pop_front(), t_qb.pop_front());
  end

  // ---------------- drivers ----------------
  // Inputs change on the falling edge; an op still queued at its start edge
  // was aborted and is dropped.
  task automatic go32(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit now);
    if (!now) @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clock);
    exp_q32.delete(); t_q32.delete();
    exp_q32.push_back(model(32, sgn, a, b));
    t_q32.push_back($time);
    #1 start = 1'b0;
  endtask

  task automatic go8(input bit sgn, input logic [7:0] a, input logic [7:0] b, input bit now);
    if (!now) @(negedge clock);
    start8 = 1'b1; is_signed8 = sgn; dvd8 = a; dvs8 = b;
    @(posedge clock);
    exp_qa.delete(); t_qa.delete(); exp_qb.delete(); t_qb.delete();
    exp_qa.push_back(model(8, sgn, {24'd0, a}, {24'd0, b}));
    exp_qb.push_back(model(8, 1'b0, {24'd0, a}, {24'd0, b}));
    t_qa.push_back($time);
    t_qb.push_back($time);
    #1 start8 = 1'b0;
  endtask

  task automatic wait_done32(input int budget);
    int k = 0;
    while (exp_q32.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("u32_drain", exp_q32.size(), 0);
  endtask

  task automatic wait_done8(input int budget);
    int k = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("u8_drain", exp_qa.size() + exp_qb.size(), 0);
  endtask

  task automatic wait_ready32(input int budget);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (ready !== 1'b1 && k < budget);
    check("u32_ready_seen", ready, 1);
  endtask

  task automatic wait_ready8(input int budget);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (ready_a !== 1'b1 && k < budget);
    check("u8_ready_seen", ready_a, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    bit          sgn;
    int          bc;

    clear = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; is_signed8 = 1'b0; dvd8 = '0; dvs8 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_exception", exception, 0);
    check("rst_state", st32, IDLE);
    check("rst_u8_outputs", {qa, ra, qb, rb, ready_a, busy_a, exc_a, ready_b, busy_b, exc_b}, 0);
    clear = 1'b0;

    // Unsigned 100/7: busy for 32 cycles, then ready
    go32(1'b0, 32'd100, 32'd7, 1'b0);
    bc = 0;
    repeat (32) begin
      @(negedge clock);
      if (busy === 1'b1 && ready === 1'b0) bc++;
    end
    check("busy_span", bc, 32);
    wait_done32(5);
    check("q_100_7", quotient, 32'd14);
    check("r_100_7", remainder, 32'd2);

    // Signed cases
    go32(1'b1, -32'sd100, 32'd7, 1'b0);
    wait_done32(40);
    check("q_m100_7", quotient, 32'hFFFF_FFF2);
    check("r_m100_7", remainder, 32'hFFFF_FFFE);
    go32(1'b1, 32'd100, -32'sd7, 1'b0);
    wait_done32(40);
    go32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done32(40);
    check("q_min_m1", quotient, 32'h8000_0000);

    // Divide by zero, then recovery
    go32(1'b0, 32'd55, 32'd0, 1'b0);
    wait_done32(5);
    repeat (2) @(negedge clock);
    check("exc_held", exception, 1);
    go32(1'b0, 32'd9, 32'd3, 1'b0);
    @(negedge clock);
    check("exc_cleared_on_start", exception, 0);
    check("busy_after_start", busy, 1);
    wait_done32(40);
    check("q_9_3", quotient, 32'd3);

    // Abort: restart mid-operation
    go32(1'b0, 32'd1000, 32'd10, 1'b0);
    repeat (9) @(negedge clock);
    go32(1'b0, 32'd81, 32'd9, 1'b0);
    wait_done32(40);

    // Clear mid-operation
    go32(1'b0, 32'd50, 32'd5, 1'b0);
    repeat (14) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    exp_q32.delete(); t_q32.delete();
    #1 clear = 1'b0;
    @(negedge clock);
    check("clr_outputs", {quotient, remainder, ready, busy, exception}, 0);
    check("clr_state", st32, IDLE);
    repeat (40) @(negedge clock);
    go32(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done32(40);

    // Back-to-back: next start in the ready cycle, then random mix
    go32(1'b0, 32'd12345, 32'd67, 1'b0);
    wait_ready32(40);
    go32(1'b1, -32'sd999, 32'd13, 1'b1);
    wait_done32(40);
    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -$urandom_range(1, 300);
        default: b = $urandom();
      endcase
      if (i % 4 == 3) begin
        wait_ready32(40);
        go32(sgn, a, b, 1'b1);
      end else begin
        wait_done32(40);
        go32(sgn, a, b, 1'b0);
      end
    end
    wait_done32(40);

    // 8-bit: signed-capable vs unsigned-only on identical stimulus
    go8(1'b1, 8'hFF, 8'h01, 1'b0);
    wait_done8(15);
    check("u8u_q_m1_1", qb, 8'hFF);
    go8(1'b1, 8'h80, 8'hFF, 1'b0);
    wait_done8(15);
    check("u8s_q_min_m1", qa, 8'h80);
    go8(1'b1, 8'hFF, 8'h02, 1'b0);
    wait_done8(15);
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255));
      b8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 4 == 3) begin
        wait_ready8(15);
        go8(sgn, a8, b8, 1'b1);
      end else begin
        wait_done8(15);
        go8(sgn, a8, b8, 1'b0);
      end
    end
    wait_done8(15);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
